// File: rtl/result_display_scanner.sv
// Snapshots one of four 32-bit datapath observation values and scans it as eight hex digits
// onto an active-low, time-multiplexed seven-segment display; a debounced button cycles the source.
module result_display_scanner #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ProgramCount,
  input  logic [31:0] CurrentMin,
  input  logic [31:0] XOut,
  input  logic [31:0] YOut,
  input  logic        SelBtn,
  input  logic        Freeze,
  output logic [7:0]  Anode,
  output logic [6:0]  Segments,
  output logic        DecimalPoint,
  output logic [1:0]  SelLeds
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_level_q, db_level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          sel_chg_q, sel_chg_d;
  logic [31:0]   snap_q, snap_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          db_diff, db_accept, press, ref_last;
  logic [31:0]   src;
  logic [3:0]    nib [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib[gi] = snap_q[4*gi +: 4];
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    // Accept on the edge the counter would reach the limit, so Sel moves that same edge.
    db_diff    = sync_q[1] ^ db_level_q;
    db_accept  = db_diff && (db_cnt_q == DB_LAST);
    db_level_d = db_accept ? sync_q[1] : db_level_q;
    db_cnt_d   = (!db_diff || db_accept) ? '0 : db_cnt_q + DW'(1);
    press      = db_accept && sync_q[1];
    sel_d      = press ? sel_q + 2'd1 : sel_q;
    sel_chg_d  = press;

    case (sel_q)
      2'd0:    src = ProgramCount;
      2'd1:    src = CurrentMin;
      2'd2:    src = XOut;
      default: src = YOut;
    endcase
    snap_d = (!Freeze || sel_chg_q) ? src : snap_q;

    ref_last  = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_last ? '0 : ref_cnt_q + RW'(1);
    digit_d   = ref_last ? digit_q + 3'd1 : digit_q;

    anode_d = ~(8'h01 << digit_q);
    seg_d   = hex7(nib[digit_q]);
    dp_d    = !((digit_q == 3'd0) && Freeze);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q     <= 2'b00;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      sel_q      <= 2'd0;
      sel_chg_q  <= 1'b0;
      snap_q     <= 32'h0;
      ref_cnt_q  <= '0;
      digit_q    <= 3'd0;
      anode_q    <= 8'hFE;
      seg_q      <= 7'h40;
      dp_q       <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], SelBtn};
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      sel_q      <= sel_d;
      sel_chg_q  <= sel_chg_d;
      snap_q     <= snap_d;
      ref_cnt_q  <= ref_cnt_d;
      digit_q    <= digit_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign Anode        = anode_q;
  assign Segments     = seg_q;
  assign DecimalPoint = dp_q;
  assign SelLeds      = sel_q;

endmodule

// File: tb/tb_result_display_scanner.sv
// Scoreboard bench for result_display_scanner: expected display states are queued as stimulus
// is applied and popped against the outputs once the design produces them.
module tb_result_display_scanner;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] ProgramCount = 32'h0, CurrentMin = 32'h0, XOut = 32'h0, YOut = 32'h0;
  logic        SelBtn = 1'b0, Freeze = 1'b0;
  logic [7:0]  Anode;
  logic [6:0]  Segments;
  logic        DecimalPoint;
  logic [1:0]  SelLeds;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  result_display_scanner #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .ProgramCount(ProgramCount), .CurrentMin(CurrentMin), .XOut(XOut), .YOut(YOut),
    .SelBtn(SelBtn), .Freeze(Freeze),
    .Anode(Anode), .Segments(Segments), .DecimalPoint(DecimalPoint), .SelLeds(SelLeds)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one = 8'h01;
    return ~(one << d);
  endfunction

  task automatic push_disp(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.tag = tag; e.an = an; e.seg = seg; e.dp = dp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      $display("txn %s an=%h seg=%h dp=%b sel=%0d", e.tag, Anode, Segments, DecimalPoint, SelLeds);
      check_val({e.tag, "_an"},  32'(Anode),        32'(e.an));
      check_val({e.tag, "_seg"}, 32'(Segments),     32'(e.seg));
      check_val({e.tag, "_dp"},  32'(DecimalPoint), 32'(e.dp));
    end
  endtask

  task automatic wait_anode(input logic [7:0] target, input int limit, input bit want_equal);
    int n = 0;
    while (((Anode === target) != want_equal) && n < limit) begin
      tick();
      n++;
    end
    if ((Anode === target) != want_equal) check_val("wait_anode_timeout", 32'(Anode), 32'(target));
  endtask

  // Queue one expected pattern per digit, then visit each digit once its dwell begins.
  task automatic scan_check(input string tag, input logic [31:0] value, input logic dp0);
    for (int d = 0; d < 8; d++)
      push_disp($sformatf("%s_d%0d", tag, d), an_of(d), SEG_TAB[value[4*d +: 4]], (d == 0) ? dp0 : 1'b1);
    wait_anode(8'hFE, 40, 1'b1);
    for (int d = 0; d < 8; d++) begin
      pop_check();
      repeat (4) tick();
    end
  endtask

  task automatic press_btn(input logic [1:0] sel_before, input logic [1:0] sel_after);
    SelBtn = 1'b1;
    repeat (9) tick();
    check_val("press_pre_accept", 32'(SelLeds), 32'(sel_before));
    tick();
    $display("txn press sel %0d -> %0d", sel_before, SelLeds);
    check_val("press_accept", 32'(SelLeds), 32'(sel_after));
    repeat (2) tick();
    SelBtn = 1'b0;
    repeat (14) tick();
    check_val("release_no_change", 32'(SelLeds), 32'(sel_after));
  endtask

  initial begin
    // 1: asynchronous reset, no clock edge
    ProgramCount = 32'hDEADBEEF; XOut = 32'h5555; SelBtn = 1'b1; Freeze = 1'b1;
    #1 Reset = 1'b0;
    #1;
    check_val("rst_an",  32'(Anode),        32'hFE);
    check_val("rst_seg", 32'(Segments),     32'h40);
    check_val("rst_dp",  32'(DecimalPoint), 32'h1);
    check_val("rst_sel", 32'(SelLeds),      32'h0);

    // 2: exact-cycle scan of source 0
    ProgramCount = 32'h89ABCDEF; SelBtn = 1'b0; Freeze = 1'b0;
    CurrentMin = 32'h00000042;
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      push_disp($sformatf("scan_c%0d", k), an_of(((k - 1) / 4) % 8),
                (k == 1) ? 7'h40 : SEG_TAB[ProgramCount[4*(((k - 1) / 4) % 8) +: 4]], 1'b1);
      tick();
      pop_check();
    end

    // 3: short pulses rejected, then a clean press selects CurrentMin
    for (int p = 0; p < 3; p++) begin
      SelBtn = 1'b1;
      repeat (3) tick();
      SelBtn = 1'b0;
      repeat (2) tick();
    end
    repeat (6) tick();
    check_val("bounce_rejected", 32'(SelLeds), 32'h0);
    press_btn(2'd0, 2'd1);
    scan_check("cmin", 32'h00000042, 1'b1);

    // 4: freeze holds XOut snapshot, release shows new value
    XOut = 32'h00001234;
    press_btn(2'd1, 2'd2);
    scan_check("xout", 32'h00001234, 1'b1);
    Freeze = 1'b1; XOut = 32'h0000FFFF;
    repeat (3) tick();
    scan_check("frz", 32'h00001234, 1'b0);
    wait_anode(8'hFE, 40, 1'b0);
    wait_anode(8'hFE, 40, 1'b1);
    Freeze = 1'b0;
    push_disp("unfrz1", 8'hFE, 7'h19, 1'b1);
    push_disp("unfrz2", 8'hFE, 7'h0E, 1'b1);
    tick(); pop_check();
    tick(); pop_check();

    // 5: wrap through all selections, then Sel change beats Freeze
    Reset = 1'b0;
    #2 Reset = 1'b1;
    check_val("rst2_sel", 32'(SelLeds), 32'h0);
    press_btn(2'd0, 2'd1);
    press_btn(2'd1, 2'd2);
    press_btn(2'd2, 2'd3);
    press_btn(2'd3, 2'd0);
    press_btn(2'd0, 2'd1);
    press_btn(2'd1, 2'd2);
    YOut = 32'h0000CAFE; Freeze = 1'b1;
    press_btn(2'd2, 2'd3);
    YOut = 32'h11111111;
    scan_check("yout", 32'h0000CAFE, 1'b0);
    check_val("yout_sel", 32'(SelLeds), 32'h3);

    // 6: async reset mid-scan on digit 5
    wait_anode(8'hDF, 40, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check_val("mid_rst_an",  32'(Anode),        32'hFE);
    check_val("mid_rst_seg", 32'(Segments),     32'h40);
    check_val("mid_rst_dp",  32'(DecimalPoint), 32'h1);
    check_val("mid_rst_sel", 32'(SelLeds),      32'h0);
    #3 Reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push_disp($sformatf("restart_c%0d", k), (k <= 4) ? 8'hFE : 8'hFD, 7'h40, (k <= 4) ? 1'b0 : 1'b1);
      tick();
      pop_check();
    end
    check_val("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
